// File: rtl/fifo_drain.sv
// fifo_drain: read-side port for a showahead synchronous FIFO.
//
// Pops entries from the FIFO head into a 2-entry skid buffer and presents
// the oldest one as a registered valid/ready stream. The dequeue request is
// built only from registered occupancy and the FIFO flags. The consumer's
// out_ready never reaches fifo_dequeue_en combinationally.
//
// Handshake: a transfer completes in any cycle where out_valid && out_ready.
// Once out_valid rises, out_valid/out_value hold until that transfer, unless
// flush_en or reset intervenes.
//
// Ports:
//   clk             in   clock
//   reset           in   synchronous active-high reset
//   flush_en        in   synchronous flush of the skid buffer
//   fifo_empty      in   FIFO empty flag
//   fifo_value      in   FIFO head data (showahead)
//   fifo_dequeue_en out  pop the FIFO head this cycle
//   out_valid       out  out_value holds a valid entry
//   out_ready       in   consumer accepts out_value this cycle
//   out_value       out  oldest buffered entry
//   transfer_count  out  completed out handshakes (wraps)
//   drained         out  FIFO empty and skid buffer empty
module fifo_drain #(
  parameter int WIDTH       = 64,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_en,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_value,
  output logic                   fifo_dequeue_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_value,
  output logic [COUNT_WIDTH-1:0] transfer_count,
  output logic                   drained
);

  logic [WIDTH-1:0]       mem_q [2];
  logic [WIDTH-1:0]       mem_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [COUNT_WIDTH-1:0] xfer_q, xfer_d;
  logic                   pop;

  // Dequeue looks only at registered occupancy, never at out_ready. A full
  // buffer therefore stalls the FIFO for one cycle after back-pressure.
  assign fifo_dequeue_en = !fifo_empty && !flush_en && !reset && (count_q != 2'd2);
  assign out_valid       = (count_q != 2'd0);
  assign out_value       = mem_q[rd_ptr_q];
  assign pop             = out_valid && out_ready;
  assign transfer_count  = xfer_q;
  assign drained         = fifo_empty && (count_q == 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A transfer in the flush cycle still counts as completed.
    xfer_d   = pop ? xfer_q + 1'b1 : xfer_q;

    if (flush_en) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (fifo_dequeue_en) begin
        mem_d[wr_ptr_q] = fifo_value;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({fifo_dequeue_en, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      xfer_q   <= '0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      xfer_q   <= xfer_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= 2'd2);
      assert (!(fifo_dequeue_en && fifo_empty));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Testbench for fifo_drain: a table of directed vectors, hand-written corner
// sequences, and randomized traffic. All of it is compared each cycle
// against a queue-based reference model.
module tb_fifo_drain;
  localparam int W  = 16;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_value = '0;
  logic          fifo_dequeue_en;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_value;
  logic [CW-1:0] transfer_count;
  logic          drained;

  always #5 clk = ~clk;

  fifo_drain #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_en       (flush_en),
    .fifo_empty     (fifo_empty),
    .fifo_value     (fifo_value),
    .fifo_dequeue_en(fifo_dequeue_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_value      (out_value),
    .transfer_count (transfer_count),
    .drained        (drained)
  );

  // ---------------- environment + reference model ----------------
  logic [W-1:0] env_q[$];   // contents of the upstream FIFO
  logic [W-1:0] exp_q[$];   // entries the port should be holding, oldest first
  int           m_tc;
  bit           m_ok;
  bit           zero_chk;

  int checks = 0;
  int errors = 0;

  // pre-edge samples of the last cycle, for directed checks
  logic          a_deq, a_valid, a_drained;
  logic [W-1:0]  a_value;
  logic [CW-1:0] a_tc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic rst, input logic fl, input logic rdy);
    logic         e_valid, e_deq, e_drained, pop;
    logic [W-1:0] head;
    @(negedge clk);
    reset      = rst;
    flush_en   = fl;
    out_ready  = rdy;
    fifo_empty = (env_q.size() == 0);
    fifo_value = (env_q.size() != 0) ? env_q[0] : '0;
    head       = fifo_value;
    #1;
    a_deq     = fifo_dequeue_en;
    a_valid   = out_valid;
    a_value   = out_value;
    a_tc      = transfer_count;
    a_drained = drained;

    e_valid   = (exp_q.size() != 0);
    e_deq     = (env_q.size() != 0) && !fl && !rst && (exp_q.size() < 2);
    e_drained = (env_q.size() == 0) && (exp_q.size() == 0);

    if (m_ok) begin
      chk("dequeue_en", a_deq, e_deq);
      chk("out_valid", a_valid, e_valid);
      chk("transfer_count", a_tc, m_tc);
      chk("drained", a_drained, e_drained);
      if (e_valid) chk("out_value", a_value, exp_q[0]);
      else if (zero_chk) chk("out_value_after_reset", a_value, 0);
    end

    @(posedge clk);
    pop = e_valid && rdy;
    if (rst) begin
      exp_q.delete();
      m_tc     = 0;
      zero_chk = 1'b1;
      m_ok     = 1'b1;
    end else begin
      zero_chk = 1'b0;
      if (pop) m_tc = (m_tc + 1) % (2 ** CW);
      if (fl) begin
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (e_deq) exp_q.push_back(head);
      end
    end
    if (a_deq && env_q.size() != 0) void'(env_q.pop_front());
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         fl;
    logic         rdy;
    logic         deq;
    logic         valid;
    logic [W-1:0] value;
    int           tc;
    logic         drn;
  } vec_t;

  vec_t tbl[5];
  logic [W-1:0] got[$];
  int n;

  initial begin
    m_ok = 1'b0;
    zero_chk = 1'b0;
    m_tc = 0;

    tbl[0] = '{fl:0, rdy:1, deq:1, valid:0, value:16'h00, tc:0, drn:0};
    tbl[1] = '{fl:0, rdy:1, deq:1, valid:1, value:16'h11, tc:0, drn:0};
    tbl[2] = '{fl:0, rdy:1, deq:1, valid:1, value:16'h22, tc:1, drn:0};
    tbl[3] = '{fl:0, rdy:1, deq:0, valid:1, value:16'h33, tc:2, drn:0};
    tbl[4] = '{fl:0, rdy:1, deq:0, valid:0, value:16'h00, tc:3, drn:1};

    // Test 1: three entries streamed with out_ready high
    cycle(1, 0, 0);
    env_q.push_back(16'h11); env_q.push_back(16'h22); env_q.push_back(16'h33);
    for (int i = 0; i < 5; i++) begin
      cycle(0, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("t1_deq[%0d]", i), a_deq, tbl[i].deq);
      chk($sformatf("t1_valid[%0d]", i), a_valid, tbl[i].valid);
      if (tbl[i].valid || i == 0) chk($sformatf("t1_value[%0d]", i), a_value, tbl[i].value);
      chk($sformatf("t1_tc[%0d]", i), a_tc, tbl[i].tc);
      chk($sformatf("t1_drained[%0d]", i), a_drained, tbl[i].drn);
    end

    // Test 2: back-pressure with four queued entries
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) env_q.push_back(W'(16'hA1 + i));
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0);
      if (a_deq) n++;
    end
    chk("t2_deq_cnt", n, 2);
    chk("t2_hold_valid", a_valid, 1);
    chk("t2_hold_value", a_value, 16'hA1);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1);
      if (a_valid) got.push_back(a_value);
    end
    chk("t2_delivered", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("t2_order[%0d]", i), got[i], W'(16'hA1 + i));

    // Test 3: alternating out_ready with ten entries
    cycle(1, 0, 0);
    for (int i = 0; i < 10; i++) env_q.push_back(W'(16'h300 + i));
    for (int i = 0; i < 30; i++) cycle(0, 0, logic'(i % 2));
    cycle(0, 0, 0);
    chk("t3_tc", a_tc, 10);
    chk("t3_drained", a_drained, 1);

    // Test 4: flush while full with a pop in the same cycle
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) env_q.push_back(W'(16'h400 + i));
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 1);
    chk("t4_flush_no_deq", a_deq, 0);
    chk("t4_flush_valid_before", a_valid, 1);
    cycle(0, 0, 0);
    chk("t4_valid_after", a_valid, 0);
    chk("t4_tc_after", a_tc, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);

    // Test 5: counter wrap at 2^CW transfers
    cycle(1, 0, 0);
    for (int i = 0; i < 16; i++) env_q.push_back(W'(16'h500 + i));
    for (int i = 0; i < 20; i++) cycle(0, 0, 1);
    chk("t5_wrap_tc", a_tc, 0);
    chk("t5_wrap_drained", a_drained, 1);

    // Test 6: reset mid-stream with full buffer and non-empty FIFO
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) env_q.push_back(W'(16'h600 + i));
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("t6_full_valid", a_valid, 1);
    cycle(1, 0, 0);
    chk("t6_reset_no_deq", a_deq, 0);
    cycle(0, 0, 1);
    chk("t6_valid_after", a_valid, 0);
    chk("t6_value_after", a_value, 0);
    chk("t6_tc_after", a_tc, 0);
    chk("t6_resume_deq", a_deq, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);

    // Random traffic against the model
    cycle(1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (env_q.size() < 8 && $urandom_range(0, 2) != 0) env_q.push_back(W'($urandom));
      cycle(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 49) == 0),
            logic'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 20; i++) cycle(0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Read-side port for the team's showahead synchronous FIFO. It dequeues entries and presents them as a registered valid/ready stream through a 2-entry skid buffer.
- The FIFO dequeue request depends only on local registered state, so there is no combinational path from consumer out_ready back to the FIFO.
- Sits between any sync_fifo instance and a downstream consumer. It also tracks the number of delivered transfers and reports when the FIFO side is fully drained.

Parameters:
- WIDTH, 64, data width; must match the FIFO width.
- COUNT_WIDTH, 32, width of the delivered-transfer counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush_en  in  1  synchronous flush; discards buffered entries.
- fifo_empty  in  1  FIFO empty flag.
- fifo_value  in  WIDTH  FIFO head data; valid in the same cycle whenever fifo_empty=0 (showahead).
- fifo_dequeue_en  out  1  pops the FIFO head this cycle.
- out_valid  out  1  out_value holds a valid entry.
- out_ready  in  1  consumer accepts out_value this cycle.
- out_value  out  WIDTH  oldest buffered entry.
- transfer_count  out  COUNT_WIDTH  number of completed out handshakes; wraps.
- drained  out  1  asserted when fifo_empty=1 and the skid buffer is empty.

Behaviour:
- Reset is synchronous, evaluated on posedge clk, and takes priority over everything. After reset: occupancy=0, read/write pointers=0, out_valid=0, out_value=0, transfer_count=0, fifo_dequeue_en=0.
- Storage: two WIDTH entries, 1-bit wr_ptr and rd_ptr, occupancy count in the range 0..2.
- out_valid = (count != 0). out_value = entry[rd_ptr].
- Entry contents are don't-care while out_valid=0, except directly after reset, when out_value reads 0.
- Dequeue rule, combinational from registered state and FIFO flags only: fifo_dequeue_en = !fifo_empty && !flush_en && !reset && (count != 2).
- On fifo_dequeue_en=1: entry[wr_ptr] <= fifo_value, and wr_ptr toggles.
- Handshake: pop = out_valid && out_ready. On pop, rd_ptr toggles.
- out_ready while out_valid=0 has no effect.
- Once out_valid=1, out_valid and out_value stay stable until pop, unless a flush or reset occurs.
- Count update:
  - dequeue only: +1.
  - pop only: -1.
  - dequeue and pop together: unchanged.
  - neither: unchanged.
- Latency: a FIFO entry popped in cycle N appears on out_value with out_valid=1 in cycle N+1, provided it is the oldest buffered entry.
- Throughput: one transfer per cycle is sustained when the FIFO is non-empty and out_ready=1 continuously; steady state count=1.
- Order: entries are delivered strictly in FIFO order, including across pointer wrap.
- Buffer full (count=2): fifo_dequeue_en=0 even if out_ready=1 in the same cycle. This stalls one cycle only after consumer back-pressure.
- Flush (flush_en=1, reset=0):
  - Next cycle: count=0, wr_ptr=rd_ptr=0, out_valid=0.
  - No dequeue in the flush cycle.
  - A pop in the flush cycle counts as completed and increments transfer_count.
  - transfer_count is not cleared by flush.
- transfer_count increments by 1 on each pop and wraps from 2^COUNT_WIDTH-1 to 0.
- drained = fifo_empty && (count == 0). It is combinational.
- Simulation assertions:
  - count never exceeds 2.
  - fifo_dequeue_en is never 1 while fifo_empty=1.

Test Plan:
- Reset, then FIFO holds A=0x11, B=0x22, C=0x33, out_ready=1 throughout:
  - fifo_dequeue_en is high for 3 cycles.
  - out_value is 0x11, 0x22, 0x33 in consecutive cycles starting one cycle after the first dequeue.
  - transfer_count=3, then drained=1.
- FIFO holds 4 entries, out_ready=0:
  - Exactly 2 dequeues, then fifo_dequeue_en=0.
  - out_valid=1 with out_value stable at the first entry.
  - Raising out_ready delivers all 4 entries in order with no duplicates or gaps.
- Alternating out_ready 1/0 with 10 queued entries:
  - The output sequence matches the input order across pointer wrap.
  - transfer_count=10.
  - count never exceeds 2.
- Buffer holds 2 entries, out_ready=1 and flush_en=1 in the same cycle:
  - Next cycle out_valid=0, count=0, transfer_count incremented by 1.
  - No FIFO dequeue in the flush cycle.
- Preload transfer_count to 2^COUNT_WIDTH-1 by forcing it, or use COUNT_WIDTH=4 and deliver 16 transfers:
  - transfer_count wraps to 0.
- Assert reset mid-stream with count=2 and fifo_empty=0:
  - Next cycle out_valid=0, out_value=0, transfer_count=0.
  - fifo_dequeue_en=0 during the reset cycle.
  - Normal draining resumes the cycle after reset deasserts.
